// File: rtl/regfile_test_monitor.sv
// Self-check monitor for the single-cycle CPU: snoops register-file writes and the
// commit stream, tracks the sub-test id, and reports a registered pass/fail verdict.
module regfile_test_monitor #(
    parameter int          XLEN         = 32,
    parameter int          TEST_ID_REG  = 1,
    parameter logic [31:0] CHECK_MASK   = 32'h80000000,
    parameter int          MEM_WORDS    = 256,
    parameter int          MAX_CYCLES   = 100000,
    parameter int          STOP_ON_FAIL = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] test_id,
    output logic [XLEN-1:0] first_fail_id,
    output logic [15:0]     fail_count,
    output logic [31:0]     cycle_count,
    output logic [1:0]      state,
    output logic            done,
    output logic            pass,
    output logic            timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    localparam logic [4:0]      TID_ADDR  = 5'(TEST_ID_REG);
    localparam logic [XLEN-3:0] MEM_LIMIT = (XLEN-2)'(MEM_WORDS);
    localparam logic [31:0]     CYC_LIMIT = 32'(MAX_CYCLES - 1);
    localparam logic [31:0]     EBREAK    = 32'h00100073;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
    endfunction

    state_t            state_r;
    logic [XLEN-1:0]   test_id_r;
    logic [XLEN-1:0]   first_fail_id_r;
    logic [15:0]       fail_count_r;
    logic [31:0]       cycle_count_r;
    logic              done_r;
    logic              pass_r;
    logic              timeout_r;

    logic              active_s;
    logic              tid_wr_s;
    logic              fail_ev_s;
    logic              halt_s;
    logic              limit_s;
    state_t            next_state_s;
    logic              next_timeout_s;
    logic [1:0]        pc_unused_s;

    assign pc_unused_s = pc[1:0];

    // Event decode: monitored cycle, id write, check-register violation, halt, timeout
    always_comb begin
        active_s  = 1'b0;
        if (state_r == ST_RUN) begin
            active_s = 1'b1;
        end else if (state_r == ST_IDLE) begin
            active_s = instr_valid;
        end else begin
            active_s = 1'b0;
        end
        tid_wr_s  = wb_en && (wb_addr == TID_ADDR) && (wb_addr != 5'd0);
        fail_ev_s = wb_en && (wb_addr != 5'd0) && CHECK_MASK[wb_addr]
                    && (wb_data != {XLEN{1'b0}});
        halt_s    = instr_valid && ((instr == EBREAK) || (pc[XLEN-1:2] >= MEM_LIMIT));
        limit_s   = (cycle_count_r == CYC_LIMIT);
    end

    // Verdict selection for a monitored cycle; stop-on-fail beats halt beats timeout
    always_comb begin
        next_state_s   = ST_RUN;
        next_timeout_s = 1'b0;
        if (fail_ev_s && (STOP_ON_FAIL != 0)) begin
            next_state_s = ST_FAIL;
        end else if (halt_s) begin
            if ((fail_count_r != 16'd0) || fail_ev_s) begin
                next_state_s = ST_FAIL;
            end else begin
                next_state_s = ST_PASS;
            end
        end else if (limit_s) begin
            next_state_s   = ST_FAIL;
            next_timeout_s = 1'b1;
        end else begin
            next_state_s = ST_RUN;
        end
    end

    // Monitor state and statistics; everything freezes once a verdict is reached
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            test_id_r       <= {XLEN{1'b0}};
            first_fail_id_r <= {XLEN{1'b0}};
            fail_count_r    <= 16'd0;
            cycle_count_r   <= 32'd0;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
            timeout_r       <= 1'b0;
        end else if (active_s) begin
            cycle_count_r <= sat_inc32(cycle_count_r);
            if (tid_wr_s) begin
                test_id_r <= wb_data;
            end else begin
                test_id_r <= test_id_r;
            end
            if (fail_ev_s) begin
                fail_count_r <= sat_inc16(fail_count_r);
                // fail_count never wraps to zero, so zero means no earlier failure
                if (fail_count_r == 16'd0) begin
                    first_fail_id_r <= test_id_r;
                end else begin
                    first_fail_id_r <= first_fail_id_r;
                end
            end else begin
                fail_count_r    <= fail_count_r;
                first_fail_id_r <= first_fail_id_r;
            end
            state_r   <= next_state_s;
            done_r    <= (next_state_s == ST_PASS) || (next_state_s == ST_FAIL);
            pass_r    <= (next_state_s == ST_PASS);
            timeout_r <= next_timeout_s;
        end else begin
            state_r         <= state_r;
            test_id_r       <= test_id_r;
            first_fail_id_r <= first_fail_id_r;
            fail_count_r    <= fail_count_r;
            cycle_count_r   <= cycle_count_r;
            done_r          <= done_r;
            pass_r          <= pass_r;
            timeout_r       <= timeout_r;
        end
    end

    assign test_id       = test_id_r;
    assign first_fail_id = first_fail_id_r;
    assign fail_count    = fail_count_r;
    assign cycle_count   = cycle_count_r;
    assign state         = state_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign timeout       = timeout_r;

endmodule
